// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: per-stage pause/bubble/flush, multi-cycle
// op sequencing in MC_STAGE, and a saturating stall-cycle counter.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no multi-cycle op; pause follows stall requests only
//   ST_MC   | multi-cycle op in MC_STAGE; r_cnt counts remaining cycles
module pipeline_stall_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int MC_STAGE   = 3,
  parameter int LEN_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  mc_start,
  input  logic [LEN_W-1:0]      mc_len,
  input  logic                  flush_req,
  input  logic                  perf_clr,
  output logic [NUM_STAGES-1:0] pause,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef enum logic {ST_IDLE, ST_MC} state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_cnt;
  logic [PERF_W-1:0]  r_stall_cycles;

  logic [NUM_STAGES-1:0] w_req_pause;
  logic [NUM_STAGES-1:0] w_flush_mask;
  logic [NUM_STAGES-1:0] w_mc_mask;
  logic [NUM_STAGES-1:0] w_pause_raw;
  logic                  w_in_mc;
  logic                  w_last;
  logic                  w_mc_hold;

  assign w_in_mc   = (r_state == ST_MC);
  assign w_last    = (r_cnt == LEN_W'(1));
  // MC-imposed hold is released in the final cycle and on abort
  assign w_mc_hold = w_in_mc && !w_last && !flush_req;

  always_comb begin
    w_req_pause  = '0;
    w_flush_mask = '0;
    w_mc_mask    = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      w_req_pause[j]  = |(stall_req >> j);
      w_flush_mask[j] = (j < MC_STAGE);
      w_mc_mask[j]    = (j <= MC_STAGE);
    end
  end

  assign w_pause_raw = w_req_pause | (w_mc_hold ? w_mc_mask : '0);

  always_comb begin
    pause  = '0;
    flush  = '0;
    bubble = '0;
    if (!rst) begin
      pause = flush_req ? (w_pause_raw & ~w_flush_mask) : w_pause_raw;
      flush = flush_req ? w_flush_mask : '0;
      for (int j = 0; j < NUM_STAGES - 1; j++) begin
        bubble[j] = pause[j] & ~pause[j+1] & ~flush[j+1];
      end
    end
  end

  assign mc_busy      = !rst && w_in_mc;
  assign mc_done      = !rst && w_in_mc && w_last && !flush_req;
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mc_start && !flush_req && (mc_len >= LEN_W'(2))) begin
            r_state <= ST_MC;
            r_cnt   <= mc_len - LEN_W'(1);
          end
        end
        ST_MC: begin
          if (flush_req || w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - LEN_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      r_stall_cycles <= '0;
    end else if (pause[0] && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

endmodule
